// File: rtl/branch_predictor_pkg.sv
// Shared constants for the IF-stage branch predictor: opcode map, branch
// kinds and the saturating-counter reset value.
package branch_predictor_pkg;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1A;
  localparam logic [5:0] OP_BGEU = 6'h1B;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_DIRECT,
    BR_COND,
    BR_IND
  } br_kind_e;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic int cnt_rst_val(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic br_kind_e decode_op(input logic [5:0] op6);
    case (op6)
      OP_B, OP_BL:                                      return BR_DIRECT;
      OP_JIRL:                                          return BR_IND;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return BR_COND;
      default:                                          return BR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// One bimodal BHT entry: a CNT_W-bit up/down counter that saturates at both
// ends and resets to weakly-not-taken.
module sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_rst_val(CNT_W));

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (inc && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!inc && cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its pre-edge inputs; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= CNT_RST;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// IF-stage predictor: bimodal BHT for conditional branches, direct-mapped BTB
// for JIRL, PC-relative targets for B/BL; trained from EX resolution.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int WORD    = 32,
  parameter int BHT_IDX = 6,
  parameter int BTB_IDX = 5,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD-1:0]   pc,
  input  logic              icache_ready,
  input  logic [WORD-1:0]   inst,
  output logic              pre_branch_out,
  output logic [WORD-1:0]   pre_pc_out,
  input  logic              upd_valid,
  input  logic [WORD-1:0]   upd_pc,
  input  logic              upd_is_cond,
  input  logic              upd_is_ind,
  input  logic              upd_taken,
  input  logic [WORD-1:0]   upd_target,
  input  logic              upd_mispredict,
  output logic [STAT_W-1:0] stat_pred,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int BHT_N = 1 << BHT_IDX;
  localparam int BTB_N = 1 << BTB_IDX;
  localparam int TAG_W = WORD - BTB_IDX - 2;

  // ---------------- lookup ----------------
  br_kind_e            kind;
  logic [25:0]         imm26;
  logic [WORD-1:0]     off26, off16, pc_plus4;
  logic [BHT_IDX-1:0]  bidx;
  logic [BTB_IDX-1:0]  tidx;
  logic [TAG_W-1:0]    tag;
  logic                taken;
  logic [WORD-1:0]     target;

  logic [CNT_W-1:0]    bht_cnt [BHT_N];
  logic [BTB_N-1:0]    btb_v_q;
  logic [TAG_W-1:0]    btb_tag_q [BTB_N];
  logic [WORD-1:0]     btb_tgt_q [BTB_N];

  assign kind     = decode_op(inst[31:26]);
  // B/BL split their immediate: inst[9:0] holds the high bits.
  assign imm26    = {inst[9:0], inst[25:10]};
  assign off26    = {{(WORD-26){imm26[25]}}, imm26} << 2;
  assign off16    = {{(WORD-16){inst[25]}}, inst[25:10]} << 2;
  assign pc_plus4 = pc + WORD'(4);
  assign bidx     = pc[BHT_IDX+1:2];
  assign tidx     = pc[BTB_IDX+1:2];
  assign tag      = pc[WORD-1:BTB_IDX+2];

  always_comb begin
    taken  = 1'b0;
    target = pc_plus4;
    case (kind)
      BR_DIRECT: begin
        taken  = 1'b1;
        target = pc + off26;
      end
      BR_COND: begin
        taken  = bht_cnt[bidx][CNT_W-1];
        target = pc + off16;
      end
      BR_IND: begin
        taken  = btb_v_q[tidx] && (btb_tag_q[tidx] == tag);
        target = btb_tgt_q[tidx];
      end
      default: ;
    endcase
  end

  assign pre_branch_out = icache_ready & taken;
  assign pre_pc_out     = pre_branch_out ? target : pc_plus4;

  // ---------------- training ----------------
  logic [BHT_IDX-1:0] upd_bidx;
  logic [BTB_IDX-1:0] upd_tidx;
  logic [BHT_N-1:0]   bht_en;
  logic               btb_wr;
  logic               unused_upd_pc_lsb;

  assign upd_bidx          = upd_pc[BHT_IDX+1:2];
  assign upd_tidx          = upd_pc[BTB_IDX+1:2];
  assign unused_upd_pc_lsb = ^upd_pc[1:0];
  // A record flagged both cond and ind is treated as cond only.
  assign btb_wr = upd_valid & upd_is_ind & upd_taken & ~upd_is_cond;

  always_comb begin
    bht_en = '0;
    if (upd_valid && upd_is_cond) bht_en[upd_bidx] = 1'b1;
  end

  for (genvar i = 0; i < BHT_N; i++) begin : g_bht
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .en   (bht_en[i]),
      .inc  (upd_taken),
      .cnt  (bht_cnt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn)       btb_v_q           <= '0;
    else if (btb_wr) btb_v_q[upd_tidx] <= 1'b1;
  end

  // NOTE: tag/target arrays carry no reset; the valid bits alone make stale
  // contents harmless, and leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rstn && btb_wr) begin
      btb_tag_q[upd_tidx] <= upd_pc[WORD-1:BTB_IDX+2];
      btb_tgt_q[upd_tidx] <= upd_target;
    end
  end

  // ---------------- statistics ----------------
  logic [STAT_W-1:0] stat_pred_q, stat_miss_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_pred_q <= '0;
      stat_miss_q <= '0;
    end else if (upd_valid) begin
      stat_pred_q <= stat_pred_q + 1'b1;
      if (upd_mispredict) stat_miss_q <= stat_miss_q + 1'b1;
    end
  end

  assign stat_pred = stat_pred_q;
  assign stat_miss = stat_miss_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Next-generation IF-stage branch predictor: parametrised bimodal BHT (saturating counters) plus a direct-mapped BTB for indirect jumps.
- Produces a predicted redirect from fetch PC and ICache instruction word. It is trained by EX-stage resolution and keeps prediction/mispredict statistics.
- Sits between the ICache output and the PC-select mux.
- Replaces the static stub that always reported not-taken.

Parameters:
- WORD, 32, data/address width.
- BHT_IDX, 6, log2 of BHT entries (64).
- BTB_IDX, 5, log2 of BTB entries (32).
- CNT_W, 2, saturating counter width.
- STAT_W, 32, statistics counter width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- pc  in  WORD  fetch PC of inst.
- icache_ready  in  1  inst valid this cycle.
- inst  in  WORD  fetched instruction.
- pre_branch_out  out  1  predict taken/redirect.
- pre_pc_out  out  WORD  predicted target.
- upd_valid  in  1  EX resolved a control-flow instruction.
- upd_pc  in  WORD  PC of resolved instruction.
- upd_is_cond  in  1  conditional branch (BEQ..BGEU).
- upd_is_ind  in  1  JIRL.
- upd_taken  in  1  actual direction.
- upd_target  in  WORD  actual target.
- upd_mispredict  in  1  prediction was wrong (qualified by upd_valid).
- stat_pred  out  STAT_W  count of upd_valid events.
- stat_miss  out  STAT_W  count of upd_valid & upd_mispredict.

Behaviour:
- Decode uses op6 = inst[31:26]:
  - direct: op6 in {0x14 B, 0x15 BL}.
  - ind: op6 == 0x13 (JIRL).
  - cond: op6 in 0x16..0x1B.
- Offsets:
  - off26 = sext({inst[9:0],inst[25:10]},WORD)<<2.
  - off16 = sext(inst[25:10])<<2.
  - Add modulo 2^WORD (wraps).
- Lookup is combinational (zero latency) from pc, inst, and current table state:
  - bidx = pc[BHT_IDX+1:2].
  - tidx = pc[BTB_IDX+1:2].
  - tag = pc[WORD-1:BTB_IDX+2].
  - direct: taken=1, target=pc+off26.
  - cond: taken=cnt[bidx][CNT_W-1], target=pc+off16.
  - ind: taken = btb_v[tidx] & (btb_tag==tag), target=btb_tgt.
  - other opcodes: taken=0.
- pre_branch_out = icache_ready & taken.
- pre_pc_out: target when pre_branch_out=1, else pc+4.
- Update happens on the rising clk when upd_valid=1:
  - Counter update when upd_is_cond: at bidx of upd_pc, increment if taken (saturate at 2^CNT_W-1), else decrement (saturate at 0).
  - BTB update when upd_is_ind & upd_taken: write valid=1, tag, and target at tidx of upd_pc, overwriting any prior entry.
  - upd_is_cond & upd_is_ind both set: illegal; cond path applies, BTB not written.
- Stats: stat_pred += upd_valid; stat_miss += upd_valid & upd_mispredict. Both wrap at 2^STAT_W.
- Same-cycle lookup and update to the same entry: lookup sees the pre-update value; new value is visible next cycle. There is no bypass.
- Reset (rstn=0 at clk edge, any cycle):
  - All counters go to weakly-not-taken (2^(CNT_W-1)-1, i.e. 01).
  - All btb_v clear. Tag/target arrays are not reset.
  - stat_pred and stat_miss go to 0.
  - Updates presented during reset are ignored.
  - Outputs are combinational, so after reset any cond predicts not-taken and any JIRL misses.

Decomposition:
- Shared header (CPU_Parameter.vh): WORD, opcode constants OP_B, OP_BL, OP_JIRL, OP_BEQ..OP_BGEU, counter reset value.
- Sub-module sat_counter: parametrised CNT_W, inputs inc/en, output cnt. The BHT is an array of these, or an equivalent reg array with a shared update function.
- The BTB stays inline.
- Decode and offset logic stay in the top module.

Test Plan:
- Reset then B at pc=0x1C000000 with off26=+0x100, icache_ready=1 -> pre_branch_out=1, pre_pc_out=0x1C000100. Same with icache_ready=0 -> 0 and 0x1C000004.
- BEQ at pc=0x1C000040 after reset -> not taken. Two upd taken at that pc -> taken, target pc+off16. Five more taken -> stays 11. Three not-taken -> 00.
- JIRL at pc=0x1C000080 -> miss (0). Upd ind taken, target 0x1C002000 -> next cycle hit. Aliasing pc=0x1C000080+(1<<(BTB_IDX+2)) -> tag mismatch, 0.
- Same-cycle update and lookup on bidx with counter=01 and taken -> that cycle predicts 0, next cycle predicts 1.
- Random 1000 updates with 20% mispredict -> stat_pred=1000, stat_miss matches the scoreboard. Preload stat at 2^STAT_W-1 via STAT_W=4 build -> wraps to 0.
- Assert rstn mid-training (counters 11, BTB valid) -> next cycle all cond predict 0, JIRL misses, stats 0.
